// File: rtl/rr_shi_rd_256.sv
// Serial-in, word-out result reader.
// Collects WORD*NWORDS bits MSB first.
// Then streams the operand out low word first over a valid/ready handshake.
module rr_shi_rd_256 #(
  parameter int WORD   = 32,
  parameter int NWORDS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            bit_in,
  input  logic            bit_we,
  input  logic            out_ready,
  output logic [WORD-1:0] dout,
  output logic            out_valid,
  output logic            done,
  output logic            ovf,
  output logic            busy
);

  localparam int TOTAL = WORD * NWORDS;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int WW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [BW-1:0] BCNT_LAST = BW'(TOTAL - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(NWORDS - 1);

  typedef enum logic {COLLECT, SEND} state_t;

  state_t           state, state_nxt;
  logic [TOTAL-1:0] sr;
  logic [BW-1:0]    bcnt;
  logic [WW-1:0]    wcnt;
  logic             hs;
  logic             last_bit;
  logic             last_word;

  assign hs        = (state == SEND) && out_ready;
  assign last_bit  = bit_we && (bcnt == BCNT_LAST);
  assign last_word = hs && (wcnt == WCNT_LAST);

  // Outputs are decoded straight from registers, so the first word is visible
  // in the cycle right after the edge that captured the final bit.
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign dout      = (state == SEND) ? sr[WORD-1:0] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next-state logic; clr forces COLLECT and overrides everything else.
  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (last_bit)  state_nxt = SEND;
      SEND:    if (last_word) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
    if (clr) state_nxt = COLLECT;
  end

  // Shift register, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      bcnt <= '0;
      wcnt <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      sr   <= '0;
      bcnt <= '0;
      wcnt <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == COLLECT) begin
        if (bit_we) begin
          sr <= {sr[TOTAL-2:0], bit_in};
          if (last_bit) begin
            bcnt <= '0;
            wcnt <= '0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end else begin
        // Bits arriving while the operand is draining are dropped but flagged.
        if (bit_we) ovf <= 1'b1;
        if (hs) begin
          sr   <= {{WORD{1'b0}}, sr[TOTAL-1:WORD]};
          wcnt <= wcnt + 1'b1;
          done <= last_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_shi_rd_256.sv
// Directed bench for rr_shi_rd_256 using immediate assertions.
`timescale 1ns/1ps
module tb_rr_shi_rd_256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_we = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        out_valid;
  logic        done;
  logic        ovf;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  rr_shi_rd_256 #(.WORD(32), .NWORDS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_we    (bit_we),
    .out_ready (out_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .done      (done),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift a full operand MSB first; checks out_valid rises exactly on the last bit.
  task automatic load(input logic [255:0] op);
    for (int i = 255; i >= 0; i--) begin
      if (i == 0) chk("valid_before_last_bit", {31'b0, out_valid}, 32'd0);
      bit_we = 1'b1;
      bit_in = op[i];
      tick();
    end
    bit_we = 1'b0;
    chk("valid_after_last_bit", {31'b0, out_valid}, 32'd1);
  endtask

  // Drain all 8 words; optionally stall one cycle before each accept.
  task automatic drain(input logic [255:0] op, input bit stall);
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      w = op[32*k +: 32];
      if (stall) begin
        out_ready = 1'b0;
        chk($sformatf("stall_word%0d", k), dout, w);
        tick();
        chk($sformatf("hold_word%0d", k), dout, w);
        chk($sformatf("hold_valid%0d", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("hold_nodone%0d", k), {31'b0, done}, 32'd0);
      end
      out_ready = 1'b1;
      chk($sformatf("word%0d", k), dout, w);
      chk($sformatf("valid%0d", k), {31'b0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("valid_low_at_done", {31'b0, out_valid}, 32'd0);
    chk("busy_low_at_done", {31'b0, busy}, 32'd0);
    chk("dout_zero_at_done", dout, 32'd0);
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  logic [255:0] op_a, op_b, ones;

  initial begin
    for (int k = 0; k < 8; k++) begin
      op_a[32*k +: 32] = 32'(k);
      op_b[32*k +: 32] = 32'hA5000000 | 32'(k * 32'h00010203);
    end
    ones = '1;

    // Reset state
    #2;
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic transfer, out_ready held high
    out_ready = 1'b1;
    load(op_a);
    chk("busy_in_send", {31'b0, busy}, 32'd1);
    drain(op_a, 1'b0);
    chk("ovf_clean", {31'b0, ovf}, 32'd0);

    // Toggling out_ready
    load(op_a);
    drain(op_a, 1'b1);

    // bit_we held through SEND
    out_ready = 1'b1;
    load(op_a);
    bit_we = 1'b1;
    bit_in = 1'b1;
    chk("ovf_before", {31'b0, ovf}, 32'd0);
    drain(op_a, 1'b0);
    bit_we = 1'b0;
    chk("ovf_sticky_after_done", {31'b0, ovf}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);

    // clr after three words accepted
    out_ready = 1'b1;
    load(op_a);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_word%0d", k), dout, 32'(k));
      tick();
    end
    out_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_dout", dout, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    tick();
    chk("abort_no_done", {31'b0, done}, 32'd0);
    load(ones);
    drain(ones, 1'b0);

    // Asynchronous reset between edges after 100 bits
    for (int i = 0; i < 100; i++) begin
      bit_we = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    bit_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dout", dout, 32'd0);
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    load(op_b);
    drain(op_b, 1'b0);

    // 255 bits, 20-cycle gap, last bit
    for (int i = 255; i >= 1; i--) begin
      bit_we = 1'b1;
      bit_in = op_b[i];
      tick();
    end
    bit_we = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("gap_valid_low", {31'b0, out_valid}, 32'd0);
    bit_we = 1'b1;
    bit_in = op_b[0];
    tick();
    bit_we = 1'b0;
    chk("gap_valid_rise", {31'b0, out_valid}, 32'd1);
    drain(op_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
